johnson_counter_n: RTL and testbench

Parametrised Johnson (twisted-ring) counter, the next generation of the team's fixed 4-bit Johnson counter. It adds generic width, count enable, up/down direction, parallel load, and a decoded phase index. It also provides a registered wrap pulse and optional self-correction of illegal ring states. It serves as a glitch-free multi-phase sequencer and timing generator in the counter library.

---
 rtl/johnson_counter_n.sv | 80 ++++++++
 tb/tb_johnson_counter_n.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_counter_n.sv
// Parametrised Johnson (twisted-ring) counter with enable, direction, parallel load,
// combinational phase decode, registered wrap pulse and optional illegal-state recovery.
module johnson_counter_n #(
  parameter int WIDTH        = 4,
  parameter bit SELF_CORRECT = 1'b1,
  parameter int IDX_W        = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [IDX_W-1:0] phase,
  output logic             wrap,
  output logic             illegal,
  output logic             err
);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_err;

  logic [WIDTH-2:0] w_trans;
  logic [IDX_W:0]   w_ones;
  logic             w_illegal;
  logic [IDX_W-1:0] w_phase;
  logic [WIDTH-1:0] w_q_fwd;
  logic [WIDTH-1:0] w_q_rev;
  logic             w_wrap_hit;

  // A legal ring word has at most one boundary between adjacent stages.
  // Its phase is the ones count when the tail stage is 0, else 2*WIDTH minus the ones count.
  always_comb begin
    w_trans   = r_q[WIDTH-1:1] ^ r_q[WIDTH-2:0];
    w_ones    = (IDX_W + 1)'($countones(r_q));
    w_illegal = ($countones(w_trans) > 1);
    w_phase   = '0;
    if (!w_illegal) begin
      if (r_q[0]) begin
        w_phase = IDX_W'(2 * WIDTH) - IDX_W'(w_ones);
      end else begin
        w_phase = IDX_W'(w_ones);
      end
    end
  end

  assign w_q_fwd    = {~r_q[0], r_q[WIDTH-1:1]};
  assign w_q_rev    = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
  assign w_wrap_hit = !w_illegal &&
                      (up ? (w_phase == IDX_W'(2 * WIDTH - 1)) : (w_phase == '0));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (load) begin
        r_q <= load_val;
      end else if (SELF_CORRECT && w_illegal) begin
        r_q   <= '0;
        r_err <= 1'b1;
      end else if (en) begin
        r_q    <= up ? w_q_fwd : w_q_rev;
        r_wrap <= w_wrap_hit;
      end
    end
  end

  assign q       = r_q;
  assign phase   = w_phase;
  assign wrap    = r_wrap;
  assign illegal = w_illegal;
  assign err     = r_err;

endmodule

// File: tb/tb_johnson_counter_n.sv
// Scoreboard bench for johnson_counter_n: three instances (W4 corrected, W4 free-running, W5 corrected)
// share stimulus; a phase-index reference model predicts every output after each edge.
module tb_johnson_counter_n;

  localparam int W_OF  [3] = '{4, 4, 5};
  localparam bit SC_OF [3] = '{1'b1, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       reset;
  logic       en, up, load;
  logic [3:0] load_val4;
  logic [4:0] load_val5;

  logic [3:0] q_a, q_b;
  logic [4:0] q_c;
  logic [2:0] phase_a, phase_b;
  logic [3:0] phase_c;
  logic       wrap_a, wrap_b, wrap_c;
  logic       ill_a, ill_b, ill_c;
  logic       err_a, err_b, err_c;

  johnson_counter_n #(.WIDTH(4), .SELF_CORRECT(1'b1)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val4),
    .q(q_a), .phase(phase_a), .wrap(wrap_a), .illegal(ill_a), .err(err_a));

  johnson_counter_n #(.WIDTH(4), .SELF_CORRECT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val4),
    .q(q_b), .phase(phase_b), .wrap(wrap_b), .illegal(ill_b), .err(err_b));

  johnson_counter_n #(.WIDTH(5), .SELF_CORRECT(1'b1)) dut_c (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val5),
    .q(q_c), .phase(phase_c), .wrap(wrap_c), .illegal(ill_c), .err(err_c));

  always #5 clk = ~clk;

  logic [7:0] act_q  [3];
  logic [7:0] act_ph [3];
  logic       act_wr [3];
  logic       act_il [3];
  logic       act_er [3];

  assign act_q[0]  = {4'b0, q_a};
  assign act_q[1]  = {4'b0, q_b};
  assign act_q[2]  = {3'b0, q_c};
  assign act_ph[0] = {5'b0, phase_a};
  assign act_ph[1] = {5'b0, phase_b};
  assign act_ph[2] = {4'b0, phase_c};
  assign act_wr[0] = wrap_a;
  assign act_wr[1] = wrap_b;
  assign act_wr[2] = wrap_c;
  assign act_il[0] = ill_a;
  assign act_il[1] = ill_b;
  assign act_il[2] = ill_c;
  assign act_er[0] = err_a;
  assign act_er[1] = err_b;
  assign act_er[2] = err_c;

  typedef struct {
    int         id;
    logic [7:0] q;
    int         phase;
    bit         wrap;
    bit         ill;
    bit         err;
  } exp_t;

  exp_t sb[$];
  event mon_ev;
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference state per instance.
  logic [7:0] m_q   [3];
  bit         m_err [3];
  bit         m_wrap[3];

  // Word for step k of the cycle: k leading ones, or (w-(k-w)) trailing ones after the midpoint.
  function automatic logic [7:0] johnson_word(input int k, input int w);
    int v;
    if (k <= w) v = ((1 << w) - 1) & ~((1 << (w - k)) - 1);
    else        v = (1 << (w - (k - w))) - 1;
    return 8'(v);
  endfunction

  function automatic int model_phase(input logic [7:0] v, input int w);
    for (int k = 0; k < 2 * w; k++) begin
      if (v == johnson_word(k, w)) return k;
    end
    return -1;
  endfunction

  task automatic push_expect(input int j);
    exp_t e;
    int   p;
    p       = model_phase(m_q[j], W_OF[j]);
    e.id    = j;
    e.q     = m_q[j];
    e.phase = (p < 0) ? 0 : p;
    e.wrap  = m_wrap[j];
    e.ill   = (p < 0);
    e.err   = m_err[j];
    sb.push_back(e);
  endtask

  task automatic model_step(input int j, input bit r, input bit e, input bit u,
                            input bit l, input logic [4:0] lv);
    int         w;
    int         p;
    logic [7:0] mask;
    w    = W_OF[j];
    mask = 8'((1 << w) - 1);
    if (r) begin
      m_q[j] = '0; m_wrap[j] = 1'b0; m_err[j] = 1'b0;
      return;
    end
    m_wrap[j] = 1'b0;
    p = model_phase(m_q[j], w);
    if (l) begin
      m_q[j] = {3'b0, lv} & mask;
    end else if (SC_OF[j] && p < 0) begin
      m_q[j]   = '0;
      m_err[j] = 1'b1;
    end else if (e) begin
      if (p >= 0) begin
        m_wrap[j] = u ? (p == 2 * w - 1) : (p == 0);
        m_q[j]    = johnson_word(u ? (p + 1) % (2 * w) : (p + 2 * w - 1) % (2 * w), w);
      end else if (u) begin
        m_q[j] = (m_q[j] >> 1) | ({7'b0, ~m_q[j][0]} << (w - 1));
      end else begin
        m_q[j] = ((m_q[j] << 1) & mask) | {7'b0, ~m_q[j][w-1]};
      end
    end
  endtask

  task automatic check(input string name, input int j, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, j, $time, act, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit u, input bit l, input logic [4:0] lv);
    @(negedge clk);
    #1;
    reset = r; en = e; up = u; load = l;
    load_val4 = lv[3:0];
    load_val5 = lv;
    for (int j = 0; j < 3; j++) begin
      model_step(j, r, e, u, l, (j == 2) ? lv : {1'b0, lv[3:0]});
      push_expect(j);
    end
  endtask

  // Asserts reset between edges and checks the immediate, clock-independent clear.
  task automatic async_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      model_step(j, 1'b1, 1'b0, 1'b0, 1'b0, 5'b0);
      push_expect(j);
    end
    -> mon_ev;
  endtask

  // Monitor: compares every pending expectation just after each edge or async event.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or mon_ev);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check("q",       e.id, 32'(act_q[e.id]),  32'(e.q));
        check("phase",   e.id, 32'(act_ph[e.id]), 32'(e.phase));
        check("wrap",    e.id, 32'(act_wr[e.id]), 32'(e.wrap));
        check("illegal", e.id, 32'(act_il[e.id]), 32'(e.ill));
        check("err",     e.id, 32'(act_er[e.id]), 32'(e.err));
      end
    end
  end

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
    load_val4 = '0; load_val5 = '0;
    #2;
    for (int j = 0; j < 3; j++) begin
      model_step(j, 1'b1, 1'b0, 1'b0, 1'b0, 5'b0);
      push_expect(j);
    end
    -> mon_ev;

    // Forward full cycle plus one, then back to 0000 on the 4-bit rings.
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'b0);
    // Reverse through the wrap, then hold.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'b0);
    // Load beats enable, then a direction flip.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 5'b01110);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'b0);
    // Illegal word: corrected with en low, or shifted freely when correction is off.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 5'b01010);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 5'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 5'b01010);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'b0);
    // Async reset from 1111 mid-cycle, held over one edge, then released.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 5'b11111);
    async_reset();
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 5'b0);
    cycle(1'b0, 1'b1, 0, 1'b0, 5'b0);
    // Long forward run: several wraps on both widths.
    for (int i = 0; i < 25; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'b0);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(49) == 0) begin
        async_reset();
      end else begin
        cycle(1'b0, $urandom_range(3) != 0, 1'($urandom), $urandom_range(7) == 0, 5'($urandom));
      end
    end

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
